// File: rtl/mul_ctrl.sv
// mul_ctrl: sequences M-extension multiply requests onto an external
// multiplier. It reuses the last product when the operands repeat and
// produces a one-cycle result pulse for the execute stage.
module mul_ctrl #(
   parameter int unsigned CACHE_EN = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        valid,
   input  logic [2:0]  funct3,
   input  logic [31:0] rs1_data,
   input  logic [31:0] rs2_data,
   input  logic        flush,
   output logic        stall,
   output logic        result_valid,
   output logic [31:0] result,
   output logic [31:0] mult_a,
   output logic [31:0] mult_b,
   output logic [2:0]  mult_sign,
   output logic        mult_start,
   input  logic [63:0] mult_product,
   input  logic        mult_done
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      RESP
   } state_t;

   state_t      state, state_nx;

   logic        req;
   logic        hit;
   logic        issue;
   logic        take_hit;
   logic        take_done;

   logic        cache_valid;
   logic [31:0] cache_a;
   logic [31:0] cache_b;
   logic [2:0]  cache_sign;
   logic [63:0] cache_product;

   // mul takes the low word, every high-half op takes the upper word
   function automatic logic [31:0] sel_half(input logic [63:0] p, input logic [2:0] code);
      return (code == 3'b000) ? p[31:0] : p[63:32];
   endfunction

   // Request qualification and last-result match; mul and mulh share one signed product
   always_comb begin
      req = valid & ~funct3[2] & ~flush;
      hit = (CACHE_EN != 0) && cache_valid &&
            (rs1_data == cache_a) && (rs2_data == cache_b) &&
            ((cache_sign == funct3) ||
             ((cache_sign[2:1] == 2'b00) && (funct3[2:1] == 2'b00)));
   end

   // Next-state logic and the strobes that load the datapath registers
   always_comb begin
      state_nx  = state;
      issue     = 1'b0;
      take_hit  = 1'b0;
      take_done = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (hit) begin
                  take_hit = 1'b1;
                  state_nx = RESP;
               end else begin
                  issue    = 1'b1;
                  state_nx = BUSY;
               end
            end
         end
         BUSY: begin
            if (flush) begin
               state_nx = IDLE;
            end else if (mult_done) begin
               take_done = 1'b1;
               state_nx  = RESP;
            end
         end
         RESP:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Status outputs are decoded from state; flush squashes a pending response
   always_comb begin
      mult_start   = (state == BUSY) & ~rst;
      result_valid = (state == RESP) & ~flush & ~rst;
      stall        = valid & ~funct3[2] & ~result_valid;
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Operand latch, result register and last-result cache
   always_ff @(posedge clk) begin
      if (rst) begin
         mult_a        <= '0;
         mult_b        <= '0;
         mult_sign     <= '0;
         result        <= '0;
         cache_valid   <= 1'b0;
         cache_a       <= '0;
         cache_b       <= '0;
         cache_sign    <= '0;
         cache_product <= '0;
      end else begin
         if (issue) begin
            mult_a    <= rs1_data;
            mult_b    <= rs2_data;
            mult_sign <= funct3;
         end
         if (take_hit) begin
            result <= sel_half(cache_product, funct3);
         end
         if (take_done) begin
            result <= sel_half(mult_product, mult_sign);
            if (CACHE_EN != 0) begin
               cache_valid   <= 1'b1;
               cache_a       <= mult_a;
               cache_b       <= mult_b;
               cache_sign    <= mult_sign;
               cache_product <= mult_product;
            end
         end
      end
   end

endmodule

// File: tb/tb_mul_ctrl.sv
// tb_mul_ctrl: directed and randomized checks of mul_ctrl against a
// behavioural multiply/cache model, with a fixed-latency multiplier responder.
module tb_mul_ctrl;

   localparam int MUL_LAT = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic        valid;
   logic [2:0]  funct3;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        flush;
   logic        stall;
   logic        result_valid;
   logic [31:0] result;
   logic [31:0] mult_a;
   logic [31:0] mult_b;
   logic [2:0]  mult_sign;
   logic        mult_start;
   logic [63:0] mult_product;
   logic        mult_done;

   int          n_chk = 0;
   int          n_fail = 0;
   int          mcnt = 0;
   logic        spur = 1'b0;
   logic [31:0] last_res;

   // reference cache: operands and code of the last completed multiply
   logic        c_valid;
   logic [31:0] c_a, c_b;
   logic [2:0]  c_f;

   logic [31:0] pool_a [3];
   logic [31:0] pool_b [3];

   mul_ctrl #(.CACHE_EN(1)) dut (
      .clk          (clk),
      .rst          (rst),
      .valid        (valid),
      .funct3       (funct3),
      .rs1_data     (rs1_data),
      .rs2_data     (rs2_data),
      .flush        (flush),
      .stall        (stall),
      .result_valid (result_valid),
      .result       (result),
      .mult_a       (mult_a),
      .mult_b       (mult_b),
      .mult_sign    (mult_sign),
      .mult_start   (mult_start),
      .mult_product (mult_product),
      .mult_done    (mult_done)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] ref_prod(input logic [31:0] a, input logic [31:0] b,
                                            input logic [2:0] f);
      logic [63:0] ea, eb;
      ea = (f == 3'b011) ? {32'h0, a} : {{32{a[31]}}, a};
      eb = (f == 3'b010 || f == 3'b011) ? {32'h0, b} : {{32{b[31]}}, b};
      return ea * eb;
   endfunction

   function automatic logic model_hit(input logic [31:0] a, input logic [31:0] b,
                                      input logic [2:0] f);
      return c_valid && (a == c_a) && (b == c_b) &&
             ((f == c_f) || (f <= 3'd1 && c_f <= 3'd1));
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // multiplier responder for the coming edge, then advance one cycle
   task automatic adv();
      #2;
      if (mult_start === 1'b1) begin
         mcnt++;
         mult_done    = (mcnt == MUL_LAT);
         mult_product = ref_prod(mult_a, mult_b, mult_sign);
      end else begin
         mcnt         = 0;
         mult_done    = spur;
         mult_product = 64'hDEAD_BEEF_0BAD_F00D;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic txn(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f);
      logic        h;
      int          lat;
      logic [63:0] p;
      logic [31:0] er;
      h   = model_hit(a, b, f);
      lat = h ? 1 : MUL_LAT + 1;
      p   = ref_prod(a, b, h ? c_f : f);
      er  = (f == 3'b000) ? p[31:0] : p[63:32];
      valid = 1'b1; rs1_data = a; rs2_data = b; funct3 = f;
      for (int c = 0; c <= lat; c++) begin
         #1;
         chk("stall", stall, c < lat);
         chk("result_valid", result_valid, c == lat);
         chk("mult_start", mult_start, !h && c >= 1 && c < lat);
         if (!h && c >= 1 && c < lat) begin
            chk("mult_a", mult_a, a);
            chk("mult_b", mult_b, b);
            chk("mult_sign", mult_sign, f);
         end
         if (c == lat) begin
            chk("result", result, er);
            last_res = result;
         end
         adv();
      end
      valid = 1'b0;
      if (!h) begin
         c_valid = 1'b1; c_a = a; c_b = b; c_f = f;
      end
   endtask

   initial begin
      logic [31:0] fa, fb;
      valid = 0; funct3 = 0; rs1_data = 0; rs2_data = 0; flush = 0;
      rst = 1; mult_done = 0; mult_product = 0; c_valid = 0;
      c_a = 0; c_b = 0; c_f = 0; last_res = 0;

      // reset state
      @(negedge clk);
      adv();
      #1;
      chk("rst_stall", stall, 0);
      chk("rst_result_valid", result_valid, 0);
      chk("rst_result", result, 0);
      chk("rst_mult_start", mult_start, 0);
      chk("rst_mult_a", mult_a, 0);
      chk("rst_mult_b", mult_b, 0);
      chk("rst_mult_sign", mult_sign, 0);
      rst = 0;
      adv();

      // signed low-word multiply, full miss latency
      txn(32'h0000_0007, 32'hFFFF_FFFD, 3'b000);
      chk("mul_neg_result", last_res, 32'hFFFF_FFEB);

      // mulhu miss then hit on identical request
      txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011);
      chk("mulhu_first", last_res, 32'hFFFF_FFFE);
      txn(32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011);
      chk("mulhu_hit", last_res, 32'hFFFF_FFFE);

      // mulh miss, then mul served from the shared signed product
      txn(32'h8000_0000, 32'h8000_0000, 3'b001);
      chk("mulh_result", last_res, 32'h4000_0000);
      txn(32'h8000_0000, 32'h8000_0000, 3'b000);
      chk("mul_after_mulh", last_res, 32'h0000_0000);

      // flush in the third cycle of a miss
      fa = 32'h1234_5678; fb = 32'h0000_0009;
      rs1_data = fa; rs2_data = fb; funct3 = 3'b000;
      for (int c = 0; c < 10; c++) begin
         valid = (c <= 3);
         flush = (c == 3);
         #1;
         chk("flush_mult_start", mult_start, c >= 1 && c <= 3);
         chk("flush_result_valid", result_valid, 0);
         adv();
      end
      flush = 1'b0;
      txn(fa, fb, 3'b000);

      // reset in the second BUSY cycle
      rs1_data = fa; rs2_data = fb; funct3 = 3'b011;
      for (int c = 0; c < 6; c++) begin
         valid = (c <= 2);
         rst   = (c == 2);
         #1;
         if (c == 1) chk("rstbusy_start_before", mult_start, 1);
         if (c >= 3) begin
            chk("rstbusy_mult_start", mult_start, 0);
            chk("rstbusy_result_valid", result_valid, 0);
            chk("rstbusy_result", result, 0);
            chk("rstbusy_mult_a", mult_a, 0);
            chk("rstbusy_mult_b", mult_b, 0);
            chk("rstbusy_mult_sign", mult_sign, 0);
         end
         adv();
      end
      rst = 1'b0;
      c_valid = 1'b0;
      txn(fa, fb, 3'b011);

      // flush while the hit response is pending
      valid = 1'b1; rs1_data = fa; rs2_data = fb; funct3 = 3'b011;
      #1;
      chk("rflush_stall0", stall, 1);
      chk("rflush_start0", mult_start, 0);
      adv();
      flush = 1'b1;
      #1;
      chk("rflush_result_valid", result_valid, 0);
      chk("rflush_stall1", stall, 1);
      adv();
      flush = 1'b0; valid = 1'b0;
      #1;
      chk("rflush_idle_rv", result_valid, 0);
      chk("rflush_idle_start", mult_start, 0);
      adv();
      txn(fa, fb, 3'b011);

      // divide codes are ignored entirely
      valid = 1'b1; funct3 = 3'b100; rs1_data = 32'h55; rs2_data = 32'h3;
      for (int c = 0; c < 8; c++) begin
         #1;
         chk("div_stall", stall, 0);
         chk("div_mult_start", mult_start, 0);
         chk("div_result_valid", result_valid, 0);
         adv();
      end
      valid = 1'b0;

      // randomized requests over a small operand pool so repeats hit
      pool_a[0] = 32'h8000_0000; pool_b[0] = 32'hFFFF_FFFF;
      pool_a[1] = $urandom;      pool_b[1] = $urandom;
      pool_a[2] = $urandom;      pool_b[2] = $urandom;
      for (int n = 0; n < 40; n++) begin
         int idx;
         idx = $urandom_range(0, 2);
         if ($urandom_range(0, 7) == 0) begin
            pool_a[idx] = $urandom;
            pool_b[idx] = $urandom;
         end
         if ($urandom_range(0, 3) == 0) begin
            spur = 1'b1;
            adv();
            spur = 1'b0;
            #1;
            chk("spur_mult_start", mult_start, 0);
            chk("spur_result_valid", result_valid, 0);
            adv();
         end
         txn(pool_a[idx], pool_b[idx], 3'($urandom_range(0, 3)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
